// File: rtl/fb_wr_arb_pkg.sv
// Shared encodings and widths for the frame-buffer write arbiter.
// Provides the FSM state type, the GRANT codes and the select decode helper.
package fb_wr_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_CLRB = 2'd1,
    ST_GNT_REG  = 2'd2,
    ST_SWITCH   = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CLRB = 2'b01;
  localparam logic [1:0] GRANT_REG  = 2'b10;

  localparam logic [1:0] SEL_CLRB = 2'b01;

  // Any select value other than SEL_CLRB means the register image.
  function automatic logic [1:0] decode_sel(input logic [1:0] sel);
    return (sel == SEL_CLRB) ? GRANT_CLRB : GRANT_REG;
  endfunction

  function automatic arb_state_t grant_state(input logic [1:0] gnt);
    return (gnt == GRANT_CLRB) ? ST_GNT_CLRB : ST_GNT_REG;
  endfunction

endpackage

// File: rtl/fb_wr_oreg.sv
// Single-entry output register with valid/ready hold toward the image store.
// A new beat may be loaded whenever the register is empty or being drained.
module fb_wr_oreg
  import fb_wr_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              out_rdy,
  output logic              out_dvld,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              can_take
);

  assign can_take = ~out_dvld | out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_dvld <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
    end else if (load) begin
      out_dvld <= 1'b1;
      out_data <= load_data;
      out_addr <= load_addr;
    end else if (out_rdy) begin
      out_dvld <= 1'b0;
    end
  end

endmodule

// File: rtl/fb_wr_arb.sv
// Arbitrates colorbar and register-image pixel writes into the image store.
// States: IDLE (post-reset pick), GNT_CLRB / GNT_REG (owner streams), SWITCH (drain before new owner).
module fb_wr_arb
  import fb_wr_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDR = 18'd153599
) (
  input  logic              CLK_100M,
  input  logic              SYS_RST,
  input  logic [1:0]        REG_SELECT,
  input  logic              CLRB_1_DVLD,
  input  logic [DATA_W-1:0] CLRB_1_DATA,
  input  logic [ADDR_W-1:0] CLRB_1_ADDR,
  output logic              CLRB_1_RDY,
  input  logic              REG_IMG_DVLD,
  input  logic [DATA_W-1:0] REG_IMG_DATA,
  input  logic [ADDR_W-1:0] REG_ADDR,
  output logic              REG_IMG_RDY,
  output logic              SLCT_IN_DVLD,
  output logic [DATA_W-1:0] SLCT_IN_DATA,
  output logic [ADDR_W-1:0] SLCT_IN_ADDR,
  input  logic              SLCT_IN_RDY,
  output logic [1:0]        GRANT,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_CNT
);

  arb_state_t        state;
  logic [1:0]        sel_grant;
  logic              can_take;
  logic              accept_clrb;
  logic              accept_reg;
  logic              accept;
  logic              frame_last;
  logic [DATA_W-1:0] mux_data;
  logic [ADDR_W-1:0] mux_addr;

  assign sel_grant = decode_sel(REG_SELECT);

  assign CLRB_1_RDY  = ~SYS_RST & (state == ST_GNT_CLRB) & can_take;
  assign REG_IMG_RDY = ~SYS_RST & (state == ST_GNT_REG) & can_take;

  assign accept_clrb = CLRB_1_DVLD & CLRB_1_RDY;
  assign accept_reg  = REG_IMG_DVLD & REG_IMG_RDY;
  assign accept      = accept_clrb | accept_reg;

  always_comb begin
    mux_data = REG_IMG_DATA;
    mux_addr = REG_ADDR;
    if (state == ST_GNT_CLRB) begin
      mux_data = CLRB_1_DATA;
      mux_addr = CLRB_1_ADDR;
    end
  end

  assign frame_last = accept & (mux_addr == LAST_ADDR);

  fb_wr_oreg u_oreg (
    .clk       (CLK_100M),
    .rst       (SYS_RST),
    .load      (accept),
    .load_data (mux_data),
    .load_addr (mux_addr),
    .out_rdy   (SLCT_IN_RDY),
    .out_dvld  (SLCT_IN_DVLD),
    .out_data  (SLCT_IN_DATA),
    .out_addr  (SLCT_IN_ADDR),
    .can_take  (can_take)
  );

  always_ff @(posedge CLK_100M) begin
    if (SYS_RST) begin
      state      <= ST_IDLE;
      GRANT      <= GRANT_NONE;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= 8'd0;
    end else begin
      FRAME_DONE <= frame_last;
      if (frame_last) begin
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          state <= grant_state(sel_grant);
          GRANT <= sel_grant;
        end
        ST_GNT_CLRB, ST_GNT_REG: begin
          // Owner changes only at a frame boundary; select glitches mid-frame are ignored.
          if (frame_last && (sel_grant != GRANT)) begin
            state <= ST_SWITCH;
            GRANT <= GRANT_NONE;
          end
        end
        ST_SWITCH: begin
          if (can_take) begin
            state <= grant_state(sel_grant);
            GRANT <= sel_grant;
          end
        end
        default: begin
          state <= ST_IDLE;
          GRANT <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

// File: doc/fb_wr_arb.md
FB_WR_ARB -- requirements
Module: fb_wr_arb

Interface
REQ-001 Parameter LAST_ADDR, default 18'd153599, address of the final pixel of a frame (320x480).
REQ-002 CLK_100M  input  1  system clock, 100 MHz; the block has one clock.
REQ-003 SYS_RST  input  1  system reset, synchronous, active-high.
REQ-004 REG_SELECT  input  2  requested display source: 2'b01 selects colorbar; any other value selects register image.
REQ-005 CLRB_1_DVLD / CLRB_1_DATA / CLRB_1_ADDR  input  1/16/18  colorbar write request: valid, pixel data, address.
REQ-006 CLRB_1_RDY  output  1  colorbar beat accepted when DVLD and RDY are both high.
REQ-007 REG_IMG_DVLD / REG_IMG_DATA / REG_ADDR  input  1/16/18  register image write request: valid, pixel data, address.
REQ-008 REG_IMG_RDY  output  1  register image beat accepted when DVLD and RDY are both high.
REQ-009 SLCT_IN_DVLD / SLCT_IN_DATA / SLCT_IN_ADDR  output  1/16/18  registered write to the image store.
REQ-010 SLCT_IN_RDY  input  1  image store accepts the output beat when DVLD and RDY are both high.
REQ-011 GRANT  output  2  current owner: 2'b00 none, 2'b01 colorbar, 2'b10 register image.
REQ-012 FRAME_DONE  output  1  one-cycle pulse when a beat with ADDR==LAST_ADDR is accepted from the granted source.
REQ-013 FRAME_CNT  output  8  count of completed frames; wraps from 255 to 0.

Function
REQ-014 FSM states: IDLE, GNT_CLRB, GNT_REG, SWITCH.
REQ-015 In IDLE, on the first cycle after reset, go to GNT_CLRB if REG_SELECT==2'b01, otherwise go to GNT_REG.
REQ-016 Only the granted source's RDY may be high: RDY = granted & (~SLCT_IN_DVLD | SLCT_IN_RDY). Both RDYs are low in IDLE and SWITCH.
REQ-017 An accepted beat loads the output register on the next edge, giving 1-cycle latency from acceptance to SLCT_IN_DVLD.
REQ-018 The output register holds DATA and ADDR stable while SLCT_IN_DVLD=1 and SLCT_IN_RDY=0.
REQ-019 SLCT_IN_DVLD clears when the held beat is accepted and no new beat is accepted in the same cycle.
REQ-020 Throughput: with SLCT_IN_RDY held at 1, one beat is transferred per cycle, with no bubbles.
REQ-021 REG_SELECT is decoded every cycle.
REQ-022 A source change takes effect only at a frame boundary: the cycle in which a beat with ADDR==LAST_ADDR is accepted while the decoded select differs from GRANT.
REQ-023 At that boundary, the FSM goes to SWITCH.
REQ-024 If REG_SELECT changes and returns to the original value before the boundary, no switch occurs.
REQ-025 SWITCH holds until the output register is empty, that is SLCT_IN_DVLD=0 or the final beat is accepted; it then moves to the newly selected GNT_x.
REQ-026 SWITCH lasts at least 1 cycle.
REQ-027 The new source is sampled on the cycle SWITCH is left.
REQ-028 Simultaneous DVLD from both sources: only the granted source is served; the other waits with RDY=0.
REQ-029 FRAME_DONE is asserted in the cycle after the last-address beat is accepted; FRAME_CNT increments on that same edge.
REQ-030 Addresses are passed through unchanged; the block performs no address arithmetic.

Reset
REQ-031 With SYS_RST=1 at a rising edge, the block enters state IDLE and sets all outputs to reset values.
REQ-032 Output reset values: SLCT_IN_DVLD=0, SLCT_IN_DATA=0, SLCT_IN_ADDR=0, GRANT=00, FRAME_DONE=0, FRAME_CNT=0, both RDY=0.
REQ-033 Reset asserted mid-frame discards any held output beat.
REQ-034 After reset is released, arbitration restarts from IDLE per REQ-015.

Structure
REQ-035 The shared package holds: the state encoding, the GRANT encodings, the SEL_CLRB=2'b01 constant, and the address and data widths 18 and 16.
REQ-036 One sub-module, fb_wr_oreg, implements the output register with valid/ready hold.
REQ-037 fb_wr_arb implements the FSM, the source mux and the frame counter.

Verification
REQ-038 Scenario 1: reset, then REG_SELECT=01 -> GRANT=01 two cycles after reset release; colorbar beat at ADDR 0 appears on SLCT_IN one cycle after acceptance.
REQ-039 Scenario 2: REG_SELECT 01->00 at colorbar ADDR 1000 -> colorbar keeps the grant through ADDR 153599; FRAME_DONE pulses; SWITCH; then GRANT=10; FRAME_CNT=1.
REQ-040 Scenario 3: SLCT_IN_RDY=0 for 5 cycles with a beat held -> DATA and ADDR stay stable; source RDY=0; no beat is lost or duplicated.
REQ-041 Scenario 4: both sources have DVLD=1 continuously with GRANT=10 -> CLRB_1_RDY never rises; REG_IMG beats stream 1 per cycle.
REQ-042 Scenario 5: SYS_RST pulsed while SLCT_IN_DVLD=1 -> next cycle SLCT_IN_DVLD=0, FRAME_CNT=0, GRANT=00.
REQ-043 Scenario 6: 256 frames completed -> FRAME_CNT wraps to 0.
